// File: rtl/sdram_bram_port.sv
// rtl/sdram_bram_port.sv - block-RAM responder for the SDRAM user-port handshake
// Serves write/read bursts from an on-chip word array, pacing acks with GAP idle cycles.
module sdram_bram_port #(
  parameter int AW  = 8,
  parameter int GAP = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        sdram_wr_req,
  input  logic        sdram_rd_req,
  input  logic [15:0] sdram_wr_addr,
  input  logic [15:0] sdram_rd_addr,
  input  logic [9:0]  sdram_wr_burst,
  input  logic [9:0]  sdram_rd_burst,
  input  logic [15:0] sdram_din,
  output logic        sdram_wr_ack,
  output logic        sdram_rd_ack,
  output logic [15:0] sdram_dout,
  output logic        busy,
  output logic        err_abort
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_CAP,
    S_RD_ADDR,
    S_ACK,
    S_GAP_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  state_t        r_state;
  logic          r_is_rd;
  logic [AW-1:0] r_start;
  logic [9:0]    r_last;
  logic [9:0]    r_cnt;
  logic [3:0]    r_gap;
  logic [15:0]   r_dout;
  logic          r_err_abort;
  logic [15:0]   r_mem [0:(2**AW)-1];

  state_t        w_next;
  state_t        w_word_state;
  logic [AW-1:0] w_addr;
  logic          w_req;
  logic          w_start_wr;
  logic          w_start_rd;
  logic          w_mem_we;
  logic          w_mem_re;
  logic          w_abort;
  logic          w_cnt_inc;
  logic          w_unused_addr;

  // Only the low AW address bits index the array; the rest are deliberately ignored.
  assign w_unused_addr = ^{sdram_wr_addr, sdram_rd_addr};

  assign w_addr       = r_start + AW'(r_cnt);
  assign w_req        = r_is_rd ? sdram_rd_req : sdram_wr_req;
  assign w_word_state = r_is_rd ? S_RD_ADDR : S_WR_CAP;

  always_comb begin
    w_next       = r_state;
    w_start_wr   = 1'b0;
    w_start_rd   = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_re     = 1'b0;
    w_abort      = 1'b0;
    w_cnt_inc    = 1'b0;
    sdram_wr_ack = 1'b0;
    sdram_rd_ack = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sdram_wr_req) begin
          w_start_wr = 1'b1;
          w_next     = S_WR_CAP;
        end else if (sdram_rd_req) begin
          w_start_rd = 1'b1;
          w_next     = S_RD_ADDR;
        end
      end
      S_WR_CAP: begin
        if (!w_req) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else begin
          w_mem_we = 1'b1;
          w_next   = S_ACK;
        end
      end
      S_RD_ADDR: begin
        if (!w_req) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else begin
          w_mem_re = 1'b1;
          w_next   = S_ACK;
        end
      end
      S_ACK: begin
        sdram_wr_ack = !r_is_rd;
        sdram_rd_ack = r_is_rd;
        if (r_cnt == r_last) begin
          w_next = S_DONE;
        end else begin
          w_cnt_inc = 1'b1;
          w_next    = (GAP == 0) ? w_word_state : S_GAP_WAIT;
        end
      end
      S_GAP_WAIT: begin
        if (!w_req) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (r_gap == GAP_LAST) begin
          w_next = w_word_state;
        end
      end
      S_DONE: begin
        // A still-held request must not start a new burst.
        if (!sdram_wr_req && !sdram_rd_req) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= S_IDLE;
      r_is_rd     <= 1'b0;
      r_start     <= '0;
      r_last      <= '0;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_dout      <= '0;
      r_err_abort <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_err_abort <= w_abort;
      r_gap       <= (r_state == S_GAP_WAIT) ? r_gap + 4'd1 : 4'd0;
      if (w_start_wr) begin
        r_is_rd <= 1'b0;
        r_start <= sdram_wr_addr[AW-1:0];
        r_last  <= (sdram_wr_burst == 10'd0) ? 10'd0 : sdram_wr_burst - 10'd1;
        r_cnt   <= '0;
      end else if (w_start_rd) begin
        r_is_rd <= 1'b1;
        r_start <= sdram_rd_addr[AW-1:0];
        r_last  <= (sdram_rd_burst == 10'd0) ? 10'd0 : sdram_rd_burst - 10'd1;
        r_cnt   <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 10'd1;
      end
      if (w_mem_re) r_dout <= r_mem[w_addr];
    end
  end

  // Array is left out of reset so contents survive a mid-burst reset.
  always_ff @(posedge sys_clk) begin
    if (w_mem_we) r_mem[w_addr] <= sdram_din;
  end

  assign sdram_dout = r_dout;
  assign err_abort  = r_err_abort;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_sdram_bram_port.sv
// tb/tb_sdram_bram_port.sv - self-checking bench for sdram_bram_port
// Read data expectations come from a bench-side memory model through a scoreboard queue.
module tb_sdram_bram_port;

  localparam int GAP = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        wr_req = 1'b0;
  logic        rd_req = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [15:0] rd_addr = '0;
  logic [9:0]  wr_burst = '0;
  logic [9:0]  rd_burst = '0;
  logic [15:0] din = '0;
  logic        wr_ack;
  logic        rd_ack;
  logic [15:0] dout;
  logic        busy;
  logic        err_abort;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] tb_mem [256];
  logic [15:0] wdat [16];
  logic [15:0] sb_q [$];

  sdram_bram_port #(.AW(8), .GAP(GAP)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .sdram_wr_req   (wr_req),
    .sdram_rd_req   (rd_req),
    .sdram_wr_addr  (wr_addr),
    .sdram_rd_addr  (rd_addr),
    .sdram_wr_burst (wr_burst),
    .sdram_rd_burst (rd_burst),
    .sdram_din      (din),
    .sdram_wr_ack   (wr_ack),
    .sdram_rd_ack   (rd_ack),
    .sdram_dout     (dout),
    .busy           (busy),
    .err_abort      (err_abort)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr_ack"}, 32'(wr_ack), 32'd0);
    check({tag, "_rd_ack"}, 32'(rd_ack), 32'd0);
    check({tag, "_dout"}, 32'(dout), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err_abort), 32'd0);
  endtask

  // Cycle 0 is the cycle whose closing edge first samples the request.
  task automatic run_burst(input bit rd, input logic [15:0] addr, input int n,
                           input int stop_after, input bit stop_rst, input bit also_rd);
    int words, k, cyc, last_c, t;
    logic [15:0] exp_d;
    words = (n == 0) ? 1 : n;
    k = 0;
    cyc = 0;
    if (rd) for (int i = 0; i < words; i++) sb_q.push_back(tb_mem[(int'(addr) + i) % 256]);
    @(negedge sys_clk);
    if (rd) begin
      rd_addr = addr; rd_burst = n[9:0]; rd_req = 1'b1;
    end else begin
      wr_addr = addr; wr_burst = n[9:0]; din = wdat[0]; wr_req = 1'b1;
      if (also_rd) rd_req = 1'b1;
    end
    while (k < words && cyc < 300) begin
      @(negedge sys_clk);
      cyc++;
      if (cyc == 1) check("busy_c1", 32'(busy), 32'd1);
      if (wr_ack && rd_ack) check("ack_both", 32'd1, 32'd0);
      if ((rd && wr_ack) || (!rd && rd_ack)) check("ack_dir", 32'd1, 32'd0);
      if ((rd && rd_ack) || (!rd && wr_ack)) begin
        check(rd ? "rd_ack_cyc" : "wr_ack_cyc", 32'(cyc), 32'(2 + k * (GAP + 2)));
        if (rd) begin
          if (sb_q.size() > 0) begin
            exp_d = sb_q.pop_front();
            check("rd_data", 32'(dout), 32'(exp_d));
          end else begin
            check("sb_underflow", 32'd1, 32'd0);
          end
        end else begin
          tb_mem[(int'(addr) + k) % 256] = wdat[k];
        end
        k++;
        if (!rd && k < words) din = wdat[k];
        if (k == stop_after) break;
      end
    end
    if (cyc >= 300) check("burst_timeout", 32'(k), 32'(words));
    last_c = cyc;
    if (stop_after != 0 && k == stop_after) begin
      if (stop_rst) begin
        sys_rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
        @(negedge sys_clk);
        check_outputs_zero("midrst");
        sys_rst = 1'b0;
      end else begin
        if (rd) rd_req = 1'b0; else wr_req = 1'b0;
        @(negedge sys_clk);
        check("abort_early", 32'(err_abort), 32'd0);
        check("abort_busy1", 32'(busy), 32'd1);
        @(negedge sys_clk);
        check("abort_pulse", 32'(err_abort), 32'd1);
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_noack", 32'(wr_ack | rd_ack), 32'd0);
        @(negedge sys_clk);
        check("abort_1cyc", 32'(err_abort), 32'd0);
      end
      sb_q.delete();
    end else begin
      if (rd) rd_req = 1'b0; else wr_req = 1'b0;
      if (!also_rd) begin
        t = 0;
        while (busy && t < 20) begin
          @(negedge sys_clk);
          cyc++;
          t++;
          if (wr_ack || rd_ack) check("extra_ack", 32'd1, 32'd0);
        end
        check("done_cyc", 32'(cyc), 32'(last_c + 2));
        check("sb_empty", 32'(sb_q.size()), 32'd0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = '0;
    repeat (3) @(negedge sys_clk);
    check_outputs_zero("reset");
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // single-word write then read back
    wdat[0] = 16'h1234;
    run_burst(1'b0, 16'h0003, 1, 0, 1'b0, 1'b0);
    run_burst(1'b1, 16'h0003, 1, 0, 1'b0, 1'b0);

    // 4-word burst wrapping past the top of the array, upper address bits ignored
    wdat[0] = 16'h0019; wdat[1] = 16'h0078; wdat[2] = 16'h002A; wdat[3] = 16'h003F;
    run_burst(1'b0, 16'h00FE, 4, 0, 1'b0, 1'b0);
    run_burst(1'b1, 16'h00FE, 4, 0, 1'b0, 1'b0);
    run_burst(1'b1, 16'hA0FF, 3, 0, 1'b0, 1'b0);

    // burst length 0 behaves as one word
    wdat[0] = 16'hBEEF;
    run_burst(1'b0, 16'h0020, 0, 0, 1'b0, 1'b0);
    run_burst(1'b1, 16'h0020, 0, 0, 1'b0, 1'b0);

    // simultaneous requests: write wins, read waits until both drop
    wdat[0] = 16'h5A5A; wdat[1] = 16'hA5A5;
    rd_addr = 16'h0010; rd_burst = 10'd2;
    run_burst(1'b0, 16'h0010, 2, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      check("both_hold_busy", 32'(busy), 32'd1);
      check("both_no_rdack", 32'(rd_ack), 32'd0);
    end
    rd_req = 1'b0;
    @(negedge sys_clk);
    check("both_idle", 32'(busy), 32'd0);
    run_burst(1'b1, 16'h0010, 2, 0, 1'b0, 1'b0);

    // abort after two words leaves the rest of the array untouched
    wdat[0] = 16'h00A0; wdat[1] = 16'h00A1; wdat[2] = 16'h00A2; wdat[3] = 16'h00A3;
    run_burst(1'b0, 16'h0040, 4, 0, 1'b0, 1'b0);
    wdat[0] = 16'h00B0; wdat[1] = 16'h00B1; wdat[2] = 16'h00B2; wdat[3] = 16'h00B3;
    run_burst(1'b0, 16'h0040, 4, 2, 1'b0, 1'b0);
    run_burst(1'b1, 16'h0040, 4, 0, 1'b0, 1'b0);

    // reset in the middle of a read burst; array contents survive
    run_burst(1'b1, 16'h00FE, 4, 2, 1'b1, 1'b0);
    @(negedge sys_clk);
    check("post_rst_idle", 32'(busy), 32'd0);
    run_burst(1'b1, 16'h00FE, 4, 0, 1'b0, 1'b0);
    run_burst(1'b1, 16'h0003, 1, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
